// File: rtl/tang_nano_pkg.sv
// Board-level constants shared by the Tang Nano designs.
// Also provides a counter width helper that never returns zero bits.
package tang_nano_pkg;

   localparam int unsigned TANG_NANO_HZ = 24_000_000;

   // $clog2 collapses to 0 for n <= 1; a counter still needs one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous bit.
// Both flops load RESET_VAL on a synchronous reset.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/button_debounce.sv
// Debounces an active-low push button and emits registered press, release
// and long-hold strobes alongside the debounced level.
module button_debounce
   import tang_nano_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = TANG_NANO_HZ / 100,
   parameter int unsigned LONG_CYCLES     = TANG_NANO_HZ
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam int unsigned DbW   = cnt_width(DEBOUNCE_CYCLES);
   localparam int unsigned HoldW = cnt_width(LONG_CYCLES);
   localparam logic [DbW-1:0]   DbLast   = DbW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);

   typedef enum logic [1:0] {
      StReleased,
      StPressChk,
      StPressed,
      StReleaseChk
   } state_e;

   logic             w_btn_s;
   state_e           r_state,         w_state_nxt;
   logic [DbW-1:0]   r_db_cnt,        w_db_cnt_nxt;
   logic [HoldW-1:0] r_hold_cnt,      w_hold_cnt_nxt;
   logic             r_long_done,     w_long_done_nxt;
   logic             r_pressed,       w_pressed_nxt;
   logic             r_press_pulse,   w_press_pulse_nxt;
   logic             r_release_pulse, w_release_pulse_nxt;
   logic             r_long_pulse,    w_long_pulse_nxt;

   // Synchronizer resets to 1 so a held button still needs a full debounce.
   sync_2ff #(
      .RESET_VAL(1'b1)
   ) u_sync (
      .clk(clk),
      .rst(rst),
      .i_d(btn_n),
      .o_q(w_btn_s)
   );

   always_comb begin
      w_state_nxt         = r_state;
      w_db_cnt_nxt        = r_db_cnt;
      w_hold_cnt_nxt      = r_hold_cnt;
      w_long_done_nxt     = r_long_done;
      w_pressed_nxt       = r_pressed;
      w_press_pulse_nxt   = 1'b0;
      w_release_pulse_nxt = 1'b0;
      w_long_pulse_nxt    = 1'b0;

      unique case (r_state)
         StReleased: begin
            if (!w_btn_s) begin
               w_state_nxt  = StPressChk;
               w_db_cnt_nxt = '0;
            end
         end
         StPressChk: begin
            if (w_btn_s) begin
               w_state_nxt = StReleased;
            end else if (r_db_cnt == DbLast) begin
               w_state_nxt       = StPressed;
               w_press_pulse_nxt = 1'b1;
               w_pressed_nxt     = 1'b1;
               w_hold_cnt_nxt    = '0;
               w_long_done_nxt   = 1'b0;
            end else begin
               w_db_cnt_nxt = r_db_cnt + 1'b1;
            end
         end
         StPressed: begin
            if (w_btn_s) begin
               w_state_nxt  = StReleaseChk;
               w_db_cnt_nxt = '0;
            end
         end
         StReleaseChk: begin
            if (!w_btn_s) begin
               w_state_nxt = StPressed;
            end else if (r_db_cnt == DbLast) begin
               w_state_nxt         = StReleased;
               w_release_pulse_nxt = 1'b1;
               w_pressed_nxt       = 1'b0;
            end else begin
               w_db_cnt_nxt = r_db_cnt + 1'b1;
            end
         end
         default: w_state_nxt = StReleased;
      endcase

      // Hold time keeps running through release bounce; fires once per press.
      if (r_state == StPressed || r_state == StReleaseChk) begin
         if (r_hold_cnt != HoldLast) begin
            w_hold_cnt_nxt = r_hold_cnt + 1'b1;
         end else if (!r_long_done) begin
            w_long_pulse_nxt = 1'b1;
            w_long_done_nxt  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= StReleased;
         r_db_cnt        <= '0;
         r_hold_cnt      <= '0;
         r_long_done     <= 1'b0;
         r_pressed       <= 1'b0;
         r_press_pulse   <= 1'b0;
         r_release_pulse <= 1'b0;
         r_long_pulse    <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_db_cnt        <= w_db_cnt_nxt;
         r_hold_cnt      <= w_hold_cnt_nxt;
         r_long_done     <= w_long_done_nxt;
         r_pressed       <= w_pressed_nxt;
         r_press_pulse   <= w_press_pulse_nxt;
         r_release_pulse <= w_release_pulse_nxt;
         r_long_pulse    <= w_long_pulse_nxt;
      end
   end

   assign pressed       = r_pressed;
   assign press_pulse   = r_press_pulse;
   assign release_pulse = r_release_pulse;
   assign long_pulse    = r_long_pulse;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus random bouncing, all
// checked against a run-length reference model of the debounced button.
module tb_button_debounce;

   localparam int unsigned D = 4;
   localparam int unsigned L = 20;

   logic clk   = 1'b0;
   logic rst   = 1'b1;
   logic btn_n = 1'b1;
   logic pressed;
   logic press_pulse;
   logic release_pulse;
   logic long_pulse;

   int checks = 0;
   int errors = 0;

   // Reference model: two-cycle input delay, then a level flips once D+1
   // consecutive samples disagree with it; long fires L cycles into a press.
   bit m_d1 = 1'b1, m_d2 = 1'b1, m_level = 1'b0, m_long_done = 1'b1;
   int m_run = 0, m_age = 0;
   bit e_press = 1'b0, e_rel = 1'b0, e_long = 1'b0;

   wire [3:0] w_act = {pressed, press_pulse, release_pulse, long_pulse};
   wire [3:0] w_exp = {m_level, e_press, e_rel, e_long};

   always #5 clk = ~clk;

   button_debounce #(
      .DEBOUNCE_CYCLES(D),
      .LONG_CYCLES(L)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_n(btn_n),
      .pressed(pressed),
      .press_pulse(press_pulse),
      .release_pulse(release_pulse),
      .long_pulse(long_pulse)
   );

   // Drive one cycle of inputs, advance the model, stop at the next negedge.
   task automatic tick(input logic b, input logic r);
      bit smp;
      btn_n = b;
      rst   = r;
      @(posedge clk);
      e_press = 1'b0;
      e_rel   = 1'b0;
      e_long  = 1'b0;
      if (r) begin
         m_d1 = 1'b1; m_d2 = 1'b1; m_level = 1'b0;
         m_run = 0; m_age = 0; m_long_done = 1'b1;
      end else begin
         smp  = m_d2;
         m_d2 = m_d1;
         m_d1 = b;
         if (m_level) begin
            m_age++;
            if (m_age == L && !m_long_done) begin
               e_long = 1'b1;
               m_long_done = 1'b1;
            end
         end
         m_run = (smp == m_level) ? m_run + 1 : 0;
         if (m_run == D + 1) begin
            m_level = !m_level;
            m_run   = 0;
            if (m_level) begin
               e_press = 1'b1;
               m_age = 0;
               m_long_done = 1'b0;
            end else begin
               e_rel = 1'b1;
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         tick(1'b1, 1'b1);
         checks++;
         if (w_act !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 0000", w_act);
         end
      end
      for (int i = 0; i < 6; i++) begin
         tick(1'b1, 1'b0);
         checks++;
         if (w_act !== w_exp) begin
            errors++;
            $display("FAIL reset_idle cyc %0d got %b want %b", i, w_act, w_exp);
         end
      end
   endtask

   task automatic test_clean_press();
      int t_press = -1;
      for (int i = 1; i <= 12; i++) begin
         tick(1'b0, 1'b0);
         checks++;
         if (w_act !== w_exp) begin
            errors++;
            $display("FAIL clean_press cyc %0d got %b want %b", i, w_act, w_exp);
         end
         if (press_pulse === 1'b1 && t_press < 0) t_press = i;
      end
      checks++;
      if (t_press != 7 || pressed !== 1'b1) begin
         errors++;
         $display("FAIL clean_press_latency got %0d/%b want 7/1", t_press, pressed);
      end
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
   endtask

   task automatic test_bounce();
      int n_press = 0, t_press = -1;
      logic [13:0] pat = 14'b0000000000_1_000;  // bit i is btn_n for step i+1
      for (int i = 1; i <= 14; i++) begin
         tick(pat[i-1], 1'b0);
         checks++;
         if (w_act !== w_exp) begin
            errors++;
            $display("FAIL bounce cyc %0d got %b want %b", i, w_act, w_exp);
         end
         if (press_pulse === 1'b1) begin
            n_press++;
            t_press = i;
         end
      end
      checks++;
      if (n_press != 1 || t_press != 11) begin
         errors++;
         $display("FAIL bounce_single got %0d@%0d want 1@11", n_press, t_press);
      end
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
   endtask

   task automatic test_long_hold();
      int t_press = -1, t_long = -1, n_long = 0, n_rel = 0;
      for (int i = 1; i <= 52; i++) begin
         tick((i > 40) ? 1'b1 : 1'b0, 1'b0);
         checks++;
         if (w_act !== w_exp) begin
            errors++;
            $display("FAIL long_hold cyc %0d got %b want %b", i, w_act, w_exp);
         end
         if (press_pulse === 1'b1) t_press = i;
         if (long_pulse === 1'b1) begin
            n_long++;
            t_long = i;
         end
         if (release_pulse === 1'b1) n_rel++;
      end
      checks++;
      if (n_long != 1 || t_long - t_press != 20) begin
         errors++;
         $display("FAIL long_once got %0d gap %0d want 1 gap 20", n_long, t_long - t_press);
      end
      checks++;
      if (n_rel != 1 || pressed !== 1'b0) begin
         errors++;
         $display("FAIL long_release got %0d/%b want 1/0", n_rel, pressed);
      end
   endtask

   task automatic test_release_bounce();
      int n_press = 0, n_rel = 0, t_rel = -1;
      logic [12:0] pat = 13'b1111111111_0_11;
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
      for (int i = 1; i <= 13; i++) begin
         tick(pat[i-1], 1'b0);
         checks++;
         if (w_act !== w_exp) begin
            errors++;
            $display("FAIL rel_bounce cyc %0d got %b want %b", i, w_act, w_exp);
         end
         if (press_pulse === 1'b1) n_press++;
         if (release_pulse === 1'b1) begin
            n_rel++;
            t_rel = i;
         end
      end
      checks++;
      if (n_press != 0 || n_rel != 1 || t_rel != 10) begin
         errors++;
         $display("FAIL rel_bounce_single got p%0d r%0d@%0d want p0 r1@10",
                  n_press, n_rel, t_rel);
      end
   endtask

   task automatic test_reset_mid_press();
      int n_rel = 0, t_press = -1;
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      checks++;
      if (w_act !== 4'b0000) begin
         errors++;
         $display("FAIL mid_reset_outputs got %b want 0000", w_act);
      end
      for (int i = 1; i <= 12; i++) begin
         tick(1'b0, 1'b0);
         checks++;
         if (w_act !== w_exp) begin
            errors++;
            $display("FAIL mid_reset cyc %0d got %b want %b", i, w_act, w_exp);
         end
         if (release_pulse === 1'b1) n_rel++;
         if (press_pulse === 1'b1 && t_press < 0) t_press = i;
      end
      checks++;
      if (n_rel != 0 || t_press != 7) begin
         errors++;
         $display("FAIL mid_reset_repress got r%0d p@%0d want r0 p@7", n_rel, t_press);
      end
      for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
   endtask

   task automatic test_random();
      int cyc = 0;
      while (cyc < 4000) begin
         logic lvl = 1'($urandom_range(0, 1));
         int len = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 45) : $urandom_range(1, 8);
         for (int k = 0; k < len; k++) begin
            logic r = ($urandom_range(0, 299) == 0);
            tick(lvl, r);
            cyc++;
            checks++;
            if (w_act !== w_exp) begin
               errors++;
               $display("FAIL random cyc %0d got %b want %b", cyc, w_act, w_exp);
            end
            checks++;
            if (press_pulse === 1'b1 && release_pulse === 1'b1) begin
               errors++;
               $display("FAIL random_exclusive cyc %0d got both strobes want one", cyc);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_press();
      test_bounce();
      test_long_hold();
      test_release_bounce();
      test_reset_mid_press();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
